// File: rtl/crossbar_pkg.sv
// rtl/crossbar_pkg.sv - shared constants, slave FSM state and width helpers for crossbar_nxm
package crossbar_pkg;

  localparam logic CMD_RD = 1'b0;
  localparam logic CMD_WR = 1'b1;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } slave_state_e;

  // Number of top address bits that pick a slave.
  function automatic int sel_w(input int ns);
    return $clog2(ns);
  endfunction

  // Width of a master index; never zero so a single-master build still has a register.
  function automatic int idx_w(input int nm);
    return (nm > 1) ? $clog2(nm) : 1;
  endfunction

endpackage

// File: rtl/xbar_arbiter.sv
// rtl/xbar_arbiter.sv - per-slave arbiter holding a grant until ack or abort (CROSSBAR_RR_EN selects round-robin)
module xbar_arbiter
  import crossbar_pkg::*;
#(
  parameter int NM    = 2,
  parameter int OWN_W = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NM-1:0]    req,
  input  logic             ack,
  output logic [OWN_W-1:0] owner,
  output logic             busy,
  output logic [OWN_W-1:0] ptr
);

  slave_state_e     state_q;
  logic [OWN_W-1:0] owner_q;
  logic [OWN_W-1:0] grant;
  logic             owner_live;
  logic             done;

  // A transaction only stays alive while its owner still requests this slave.
  assign owner_live = req[owner_q];
  assign done       = (state_q == BUSY) && owner_live && ack;

  // Pick the first requester at or after the pointer, wrapping modulo NM.
  always_comb begin
    grant = '0;
    for (int k = NM - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % NM]) grant = OWN_W'((int'(ptr) + k) % NM);
    end
  end

  // Slave FSM: latch an owner from IDLE, release on ack or when the owner walks away.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|req) begin
            owner_q <= grant;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (!owner_live || done) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef CROSSBAR_RR_EN
  logic [OWN_W-1:0] ptr_q;

  // Move priority just past the master that completed; aborts leave it alone.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
    end else if (done) begin
      ptr_q <= OWN_W'((int'(owner_q) + 1) % NM);
    end
  end

  assign ptr = ptr_q;
`else
  assign ptr = '0;
`endif

  assign owner = owner_q;
  assign busy  = (state_q == BUSY);

endmodule

// File: rtl/crossbar_nxm.sv
// rtl/crossbar_nxm.sv - NM x NS crossbar top: address decode, per-slave arbiters, data muxes (option CROSSBAR_RR_EN)
module crossbar_nxm
  import crossbar_pkg::*;
#(
  parameter int NM     = 2,
  parameter int NS     = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NM-1:0]                m_req,
  input  logic [NM-1:0]                m_cmd,
  input  logic [NM-1:0][ADDR_W-1:0]    m_addr,
  input  logic [NM-1:0][DATA_W-1:0]    m_wdata,
  output logic [NM-1:0]                m_ack,
  output logic [NM-1:0][DATA_W-1:0]    m_rdata,
  output logic [NS-1:0]                s_req,
  output logic [NS-1:0]                s_cmd,
  output logic [NS-1:0][ADDR_W-1:0]    s_addr,
  output logic [NS-1:0][DATA_W-1:0]    s_wdata,
  input  logic [NS-1:0]                s_ack,
  input  logic [NS-1:0][DATA_W-1:0]    s_rdata
);

  localparam int SEL_W = sel_w(NS);
  localparam int OWN_W = idx_w(NM);

  logic [NS-1:0][NM-1:0]    req_vec;
  logic [NS-1:0][OWN_W-1:0] owner;
  logic [NS-1:0][OWN_W-1:0] ptr;
  logic [NS-1:0]            busy;

  for (genvar s = 0; s < NS; s++) begin : g_slave
    for (genvar i = 0; i < NM; i++) begin : g_dec
      assign req_vec[s][i] = m_req[i] && (m_addr[i][ADDR_W-1 -: SEL_W] == SEL_W'(s));
    end

    xbar_arbiter #(
      .NM    (NM),
      .OWN_W (OWN_W)
    ) u_arb (
      .clk   (clk),
      .reset (reset),
      .req   (req_vec[s]),
      .ack   (s_ack[s]),
      .owner (owner[s]),
      .busy  (busy[s]),
      .ptr   (ptr[s])
    );
  end

  // Forward the owner's request to each busy slave and steer its ack/rdata back.
  always_comb begin
    s_req   = '0;
    s_cmd   = '0;
    s_addr  = '0;
    s_wdata = '0;
    m_ack   = '0;
    m_rdata = '0;
    for (int s = 0; s < NS; s++) begin
      if (busy[s] && req_vec[s][owner[s]]) begin
        s_req[s]   = 1'b1;
        s_cmd[s]   = m_cmd[owner[s]];
        s_addr[s]  = m_addr[owner[s]];
        s_wdata[s] = m_wdata[owner[s]];
        if (s_ack[s]) begin
          m_ack[owner[s]]   = 1'b1;
          m_rdata[owner[s]] = s_rdata[s];
        end
      end
    end
  end

endmodule

// File: tb/tb_crossbar_nxm.sv
// tb/tb_crossbar_nxm.sv - self-checking bench for crossbar_nxm with a behavioural reference model
module tb_crossbar_nxm;

  localparam int NM     = 2;
  localparam int NS     = 2;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic                      clk = 1'b0;
  logic                      reset;
  logic [NM-1:0]             m_req;
  logic [NM-1:0]             m_cmd;
  logic [NM-1:0][ADDR_W-1:0] m_addr;
  logic [NM-1:0][DATA_W-1:0] m_wdata;
  logic [NM-1:0]             m_ack;
  logic [NM-1:0][DATA_W-1:0] m_rdata;
  logic [NS-1:0]             s_req;
  logic [NS-1:0]             s_cmd;
  logic [NS-1:0][ADDR_W-1:0] s_addr;
  logic [NS-1:0][DATA_W-1:0] s_wdata;
  logic [NS-1:0]             s_ack;
  logic [NS-1:0][DATA_W-1:0] s_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  bit mb [NS];
  int mo [NS];
  int mp [NS];

  logic [NM-1:0]             e_mack;
  logic [NM-1:0][DATA_W-1:0] e_mrd;
  logic [NS-1:0]             e_sreq;
  logic [NS-1:0]             e_scmd;
  logic [NS-1:0][ADDR_W-1:0] e_saddr;
  logic [NS-1:0][DATA_W-1:0] e_swd;

  logic [DATA_W-1:0] wd0, wd1;

  always #5 clk = ~clk;

  crossbar_nxm #(.NM(NM), .NS(NS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset),
    .m_req(m_req), .m_cmd(m_cmd), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ack(m_ack), .m_rdata(m_rdata),
    .s_req(s_req), .s_cmd(s_cmd), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_ack(s_ack), .s_rdata(s_rdata)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int tgt(input int i);
    return int'(m_addr[i][ADDR_W-1]);
  endfunction

  // Expected outputs: a busy slave mirrors its owner as long as the owner still asks for it.
  task automatic model_outputs();
    e_mack = '0; e_mrd = '0; e_sreq = '0; e_scmd = '0; e_saddr = '0; e_swd = '0;
    for (int s = 0; s < NS; s++) begin
      if (mb[s] && m_req[mo[s]] && tgt(mo[s]) == s) begin
        e_sreq[s]  = 1'b1;
        e_scmd[s]  = m_cmd[mo[s]];
        e_saddr[s] = m_addr[mo[s]];
        e_swd[s]   = m_wdata[mo[s]];
        if (s_ack[s]) begin
          e_mack[mo[s]] = 1'b1;
          e_mrd[mo[s]]  = s_rdata[s];
        end
      end
    end
  endtask

  task automatic model_update();
    for (int s = 0; s < NS; s++) begin
      if (reset) begin
        mb[s] = 0; mo[s] = 0; mp[s] = 0;
      end else if (!mb[s]) begin
        for (int k = 0; k < NM; k++) begin
          int i;
          i = (mp[s] + k) % NM;
          if (!mb[s] && m_req[i] && tgt(i) == s) begin
            mb[s] = 1; mo[s] = i;
          end
        end
      end else if (!(m_req[mo[s]] && tgt(mo[s]) == s)) begin
        mb[s] = 0;
      end else if (s_ack[s]) begin
        mb[s] = 0;
`ifdef CROSSBAR_RR_EN
        mp[s] = (mo[s] + 1) % NM;
`endif
      end
    end
  endtask

  // Inputs are already applied; compare at the falling edge, then step the model at the rising edge.
  task automatic tick();
    @(negedge clk);
    model_outputs();
    chk("s_req", 64'(s_req), 64'(e_sreq));
    chk("s_cmd", 64'(s_cmd), 64'(e_scmd));
    chk("m_ack", 64'(m_ack), 64'(e_mack));
    for (int s = 0; s < NS; s++) begin
      chk($sformatf("s_addr%0d", s), 64'(s_addr[s]), 64'(e_saddr[s]));
      chk($sformatf("s_wdata%0d", s), 64'(s_wdata[s]), 64'(e_swd[s]));
    end
    for (int i = 0; i < NM; i++) chk($sformatf("m_rdata%0d", i), 64'(m_rdata[i]), 64'(e_mrd[i]));
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle_inputs();
    m_req = '0; m_cmd = '0; m_addr = '0; m_wdata = '0; s_ack = '0; s_rdata = '0;
  endtask

  initial begin
    for (int s = 0; s < NS; s++) begin mb[s] = 0; mo[s] = 0; mp[s] = 0; end
    idle_inputs();
    reset = 1'b1;
    @(posedge clk); #1;
    tick();
    reset = 1'b0;
    #1;
    chk("rst_s_req", 64'(s_req), 64'd0);
    chk("rst_m_ack", 64'(m_ack), 64'd0);

    // single read by m0 to slave 0, acked three cycles after the request
    m_req = 2'b01; m_cmd[0] = 1'b0; m_addr[0] = 32'h0000_0010;
    #1 chk("rd_t_s_req", 64'(s_req), 64'd0);
    tick();
    chk("rd_t1_s_req", 64'(s_req), 64'b01);
    tick();
    tick();
    s_ack = 2'b01; s_rdata[0] = 32'hA5A5_A5A5;
    #1;
    chk("rd_t3_m_ack", 64'(m_ack), 64'b01);
    chk("rd_t3_m_rdata", 64'(m_rdata[0]), 64'hA5A5_A5A5);
    tick();
    m_req = '0; s_ack = '0;
    #1 chk("rd_t4_s_req", 64'(s_req), 64'd0);
    tick();

    // parallel writes to different slaves
    wd0 = 32'h1111_2222; wd1 = 32'h3333_4444;
    m_req = 2'b11; m_cmd = 2'b11;
    m_addr[0] = 32'h0000_0004; m_addr[1] = 32'h8000_0004;
    m_wdata[0] = wd0; m_wdata[1] = wd1;
    tick();
    chk("par_s_req", 64'(s_req), 64'b11);
    chk("par_wd0", 64'(s_wdata[0]), 64'(wd0));
    chk("par_wd1", 64'(s_wdata[1]), 64'(wd1));
    s_ack = 2'b11;
    #1 chk("par_m_ack", 64'(m_ack), 64'b11);
    tick();
    idle_inputs();
    tick();

    // contention on slave 1
    m_req = 2'b11; m_addr[0] = 32'h8000_0000; m_addr[1] = 32'h8000_0000;
    m_wdata[0] = wd0; m_wdata[1] = wd1;
    tick();
    chk("cont_first", 64'(s_wdata[1]), 64'(wd0));
    s_ack = 2'b10;
    #1 chk("cont_ack_m0", 64'(m_ack), 64'b01);
    tick();
    s_ack = '0;
    tick();
`ifdef CROSSBAR_RR_EN
    chk("cont_second", 64'(s_wdata[1]), 64'(wd1));
`else
    chk("cont_second", 64'(s_wdata[1]), 64'(wd0));
`endif
    idle_inputs();
    tick();
    tick();

    // abort by m1
    m_req = 2'b10; m_addr[1] = 32'h8000_0000;
    tick();
    chk("abt_s_req", 64'(s_req), 64'b10);
    m_req = '0;
    tick();
    chk("abt_s_req_low", 64'(s_req), 64'd0);
    s_ack = 2'b10;
    #1 chk("abt_no_ack", 64'(m_ack), 64'd0);
    tick();
    idle_inputs();
    tick();

    // reset while busy with an ack pending
    m_req = 2'b01; m_addr[0] = 32'h0000_0020;
    tick();
    s_ack = 2'b01; s_rdata[0] = 32'hDEAD_BEEF; reset = 1'b1;
    tick();
    reset = 1'b0; s_ack = '0;
    #1;
    chk("rstb_s_req", 64'(s_req), 64'd0);
    chk("rstb_m_ack", 64'(m_ack), 64'd0);
    chk("rstb_m_rdata", 64'(m_rdata[0]), 64'd0);
    chk("rstb_busy", 64'(dut.g_slave[0].u_arb.busy), 64'd0);
    chk("rstb_ptr", 64'(dut.g_slave[0].u_arb.ptr), 64'd0);
    idle_inputs();
    tick();

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NM; i++) begin
        if (e_mack[i]) m_req[i] = 1'b0;
        else if ($urandom_range(0, 4) == 0) m_req[i] = ~m_req[i];
        if ($urandom_range(0, 9) == 0) m_addr[i] = $urandom;
        else m_addr[i][15:0] = 16'($urandom);
        m_cmd[i]   = 1'($urandom);
        m_wdata[i] = $urandom;
      end
      for (int s = 0; s < NS; s++) begin
        s_ack[s]   = ($urandom_range(0, 2) == 0);
        s_rdata[s] = $urandom;
      end
      reset = ($urandom_range(0, 99) == 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
